data_mem_ctrl: RTL

Load/store controller that sits directly upstream of the 128×32 word-addressed data memory and drives its write-enable, word address and write data. It accepts byte-addressed load/store requests of byte, halfword or word size from the CPU datapath. Subword stores are done as read-modify-write sequences, and load data is sign- or zero-extended. A single request is in flight at a time, under a ready/req/done handshake.

---
 rtl/data_mem_ctrl_if.sv | 24 ++
 rtl/data_mem_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// CPU-side load/store handshake for data_mem_ctrl: request fields in,
// ready/done/err status and load result out.
interface data_mem_ctrl_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, sext, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, wr, size, sext, addr, wdata,
    output ready, done, err, rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store controller in front of a 128x32 word memory: byte/half/word
// accesses, read-modify-write for subword stores, sign/zero-extended loads.
module data_mem_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_ctrl_if.slave       bus,
  output logic                 mem_we,
  output logic [6:0]           mem_addr,
  output logic [31:0]          mem_din,
  input  logic [31:0]          mem_dout
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, next_state;
  logic        lat_wr;
  logic [1:0]  lat_size;
  logic        lat_sext;
  logic [8:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic [31:0] load_val;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        accept;
  logic        bad_in;
  logic        lat_bad;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) || (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
  endfunction

  assign accept  = (state == IDLE) && bus.req;
  assign bad_in  = misaligned(bus.size, bus.addr[1:0]);
  assign lat_bad = misaligned(lat_size, lat_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Word stores skip the read; everything else valid goes through RD first.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (bad_in)                             next_state = RESP;
          else if (bus.wr && bus.size == 2'b10)   next_state = WR;
          else                                    next_state = RD;
        end
      end
      RD:      next_state = lat_wr ? WR : RESP;
      WR:      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    lane_byte = mem_dout[{lat_addr[1:0], 3'b000} +: 8];
    lane_half = lat_addr[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (lat_size)
      2'b00:   load_val = {{24{lat_sext & lane_byte[7]}}, lane_byte};
      2'b01:   load_val = {{16{lat_sext & lane_half[15]}}, lane_half};
      default: load_val = mem_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_wr    <= 1'b0;
      lat_size  <= 2'b00;
      lat_sext  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      merge_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        lat_wr    <= bus.wr;
        lat_size  <= bus.size;
        lat_sext  <= bus.sext;
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
        if (bad_in) rdata_q <= '0;
      end
      if (state == RD) begin
        if (lat_wr) merge_q <= mem_dout;
        else        rdata_q <= load_val;
      end
    end
  end

  // Splice the store lane(s) into the word captured during RD.
  always_comb begin
    mem_din = merge_q;
    case (lat_size)
      2'b00:   mem_din[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      2'b01:   mem_din[{lat_addr[1], 4'b0000} +: 16] = lat_wdata[15:0];
      default: mem_din = lat_wdata;
    endcase
  end

  assign mem_we    = (state == WR) && !rst;
  assign mem_addr  = lat_addr[8:2];
  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == RESP);
  assign bus.err   = (state == RESP) && lat_bad;
  assign bus.rdata = rdata_q;

endmodule
